// File: rtl/mc_main_cntl.sv
// mc_main_cntl -- multicycle main control FSM for the MIPS core.
//
// Sequences the shared ALU, memory port, IR, PC and register file through
// fetch / decode / execute / memory / writeback cycles. All control outputs
// are decoded from the current state. In FETCH, oPCWrite and oIRWrite are
// also gated by iMemReady. A retired-fetch counter and a one-cycle
// illegal-opcode flag are also provided.
//
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   iOpcode[5:0]         IR[31:26], meaningful from DECODE onward
//   iMemReady            memory completes the current access this cycle
//   oPCWrite/oPCWriteCond/oPCSource   PC update controls
//   oIorD/oMemRead/oMemWrite          memory port controls
//   oIRWrite                          IR load
//   oMemtoReg/oRegDst/oRegWrite       register file write controls
//   oALUSrcA/oALUSrcB/oALUOp          ALU operand and operation selects
//   oIllegal             one-cycle pulse on an unsupported opcode
//   oState[3:0]          current state code (debug)
//   oInstCount[CNT_W-1:0] completed instruction fetches (wraps)
module mc_main_cntl #(
  parameter int          CNT_W    = 32,
  parameter logic [5:0]  OP_RTYPE = 6'h00,
  parameter logic [5:0]  OP_LW    = 6'h23,
  parameter logic [5:0]  OP_SW    = 6'h2B,
  parameter logic [5:0]  OP_BEQ   = 6'h04,
  parameter logic [5:0]  OP_J     = 6'h02
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [5:0]       iOpcode,
  input  logic             iMemReady,
  output logic             oPCWrite,
  output logic             oPCWriteCond,
  output logic             oIorD,
  output logic             oMemRead,
  output logic             oMemWrite,
  output logic             oIRWrite,
  output logic             oMemtoReg,
  output logic             oRegDst,
  output logic             oRegWrite,
  output logic             oALUSrcA,
  output logic [1:0]       oALUSrcB,
  output logic [1:0]       oALUOp,
  output logic [1:0]       oPCSource,
  output logic             oIllegal,
  output logic [3:0]       oState,
  output logic [CNT_W-1:0] oInstCount
);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    FETCH   = 4'd1,
    DECODE  = 4'd2,
    MEMADR  = 4'd3,
    MEMRD   = 4'd4,
    MEMWB   = 4'd5,
    MEMWR   = 4'd6,
    EXEC    = 4'd7,
    RWB     = 4'd8,
    BRANCH  = 4'd9,
    JUMP    = 4'd10,
    ILLEGAL = 4'd11
  } state_t;

  state_t state, stateNxt;

  // The fetch retires when memory returns the instruction word.
  logic fetchDone;
  assign fetchDone = (state == FETCH) && iMemReady;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= stateNxt;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)        oInstCount <= '0;
    else if (fetchDone) oInstCount <= oInstCount + 1'b1;
  end

  // Next-state logic
  always_comb begin
    stateNxt = FETCH;
    unique case (state)
      IDLE:    stateNxt = FETCH;
      FETCH:   stateNxt = iMemReady ? DECODE : FETCH;
      DECODE: begin
        if (iOpcode == OP_LW || iOpcode == OP_SW) stateNxt = MEMADR;
        else if (iOpcode == OP_RTYPE)             stateNxt = EXEC;
        else if (iOpcode == OP_BEQ)               stateNxt = BRANCH;
        else if (iOpcode == OP_J)                 stateNxt = JUMP;
        else                                      stateNxt = ILLEGAL;
      end
      // IR holds the opcode, so it is still valid here.
      MEMADR:  stateNxt = (iOpcode == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   stateNxt = iMemReady ? MEMWB : MEMRD;
      MEMWB:   stateNxt = FETCH;
      MEMWR:   stateNxt = iMemReady ? FETCH : MEMWR;
      EXEC:    stateNxt = RWB;
      RWB:     stateNxt = FETCH;
      BRANCH:  stateNxt = FETCH;
      JUMP:    stateNxt = FETCH;
      ILLEGAL: stateNxt = FETCH;
      default: stateNxt = FETCH;  // unused codes recover through FETCH
    endcase
  end

  // Output decode: everything defaults to 0 and is raised per state.
  always_comb begin
    oPCWrite     = 1'b0;
    oPCWriteCond = 1'b0;
    oIorD        = 1'b0;
    oMemRead     = 1'b0;
    oMemWrite    = 1'b0;
    oIRWrite     = 1'b0;
    oMemtoReg    = 1'b0;
    oRegDst      = 1'b0;
    oRegWrite    = 1'b0;
    oALUSrcA     = 1'b0;
    oALUSrcB     = 2'b00;
    oALUOp       = 2'b00;
    oPCSource    = 2'b00;
    oIllegal     = 1'b0;
    unique case (state)
      FETCH: begin
        // PC+4 is computed every FETCH cycle. PC and IR are loaded only
        // when the instruction word is returned.
        oMemRead = 1'b1;
        oALUSrcB = 2'b01;
        oPCWrite = iMemReady;
        oIRWrite = iMemReady;
      end
      DECODE: begin
        // Branch target computed in advance into ALUOut.
        oALUSrcB = 2'b11;
      end
      MEMADR: begin
        oALUSrcA = 1'b1;
        oALUSrcB = 2'b10;
      end
      MEMRD: begin
        oMemRead = 1'b1;
        oIorD    = 1'b1;
      end
      MEMWB: begin
        oRegWrite = 1'b1;
        oMemtoReg = 1'b1;
      end
      MEMWR: begin
        oMemWrite = 1'b1;
        oIorD     = 1'b1;
      end
      EXEC: begin
        oALUSrcA = 1'b1;
        oALUOp   = 2'b10;
      end
      RWB: begin
        oRegWrite = 1'b1;
        oRegDst   = 1'b1;
      end
      BRANCH: begin
        oALUSrcA     = 1'b1;
        oALUOp       = 2'b01;
        oPCWriteCond = 1'b1;
        oPCSource    = 2'b01;
      end
      JUMP: begin
        oPCWrite  = 1'b1;
        oPCSource = 2'b10;
      end
      ILLEGAL: begin
        // PC already advanced in FETCH, so the bad instruction is skipped.
        oIllegal = 1'b1;
      end
      default: ;
    endcase
  end

  assign oState = state;

endmodule
